opnd_fetch_seq: RTL



---
 rtl/opnd_fetch_seq.sv | 284 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/opnd_fetch_seq.sv
// Operand fetch sequencer: captures a bundle of operand descriptors, resolves one slot per cycle.
// Optional macro OPND_HINT_FAULT_EN enables fault reporting for memory slots with no matching read hint.
module opnd_fetch_seq #(
    parameter int NUM_OPNDS = 3,
    parameter int NUM_HINTS = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2*NUM_OPNDS-1:0] opnd_kind,
    input  logic [3*NUM_OPNDS-1:0] opnd_regsel,
    input  logic [3*NUM_OPNDS-1:0] opnd_base_sel,
    input  logic [3*NUM_OPNDS-1:0] opnd_index_sel,
    input  logic [NUM_OPNDS-1:0]   opnd_base_en,
    input  logic [NUM_OPNDS-1:0]   opnd_index_en,
    input  logic [2*NUM_OPNDS-1:0] opnd_scale,
    input  logic [32*NUM_OPNDS-1:0] opnd_disp,
    input  logic [32*NUM_OPNDS-1:0] opnd_imm,
    input  logic [255:0]           regs,
    input  logic [NUM_HINTS-1:0]   hint_valid,
    input  logic [NUM_HINTS-1:0]   hint_is_write,
    input  logic [32*NUM_HINTS-1:0] hint_address,
    input  logic [32*NUM_HINTS-1:0] hint_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [32*NUM_OPNDS-1:0] opnd_val,
    output logic [32*NUM_OPNDS-1:0] opnd_addr,
    output logic                   fault,
    output logic [1:0]             fault_idx
);

    typedef enum logic [1:0] {IDLE = 2'd0, RESOLVE = 2'd1, DONE = 2'd2} state_t;

    localparam logic [1:0] LAST_SLOT = 2'(NUM_OPNDS - 1);

    state_t                   state_q, state_d;
    logic [1:0]               cnt_q, cnt_d;
    logic                     in_ready_q, in_ready_d;
    logic                     out_valid_q, out_valid_d;
    logic [32*NUM_OPNDS-1:0]  val_q, val_d;
    logic [32*NUM_OPNDS-1:0]  addr_q, addr_d;

    // Captured transaction state
    logic [2*NUM_OPNDS-1:0]   kind_q, kind_d;
    logic [3*NUM_OPNDS-1:0]   regsel_q, regsel_d;
    logic [3*NUM_OPNDS-1:0]   base_sel_q, base_sel_d;
    logic [3*NUM_OPNDS-1:0]   index_sel_q, index_sel_d;
    logic [NUM_OPNDS-1:0]     base_en_q, base_en_d;
    logic [NUM_OPNDS-1:0]     index_en_q, index_en_d;
    logic [2*NUM_OPNDS-1:0]   scale_q, scale_d;
    logic [32*NUM_OPNDS-1:0]  disp_q, disp_d;
    logic [32*NUM_OPNDS-1:0]  imm_q, imm_d;
    logic [255:0]             regs_q, regs_d;
    logic [NUM_HINTS-1:0]     hv_q, hv_d;
    logic [NUM_HINTS-1:0]     hw_q, hw_d;
    logic [32*NUM_HINTS-1:0]  ha_q, ha_d;
    logic [32*NUM_HINTS-1:0]  hd_q, hd_d;

`ifdef OPND_HINT_FAULT_EN
    logic                     fault_q, fault_d;
    logic [1:0]               fault_idx_q, fault_idx_d;
`endif

    // Current slot decode
    logic [1:0]  cur_kind;
    logic [2:0]  cur_regsel, cur_base_sel, cur_index_sel;
    logic        cur_base_en, cur_index_en;
    logic [1:0]  cur_scale;
    logic [31:0] cur_disp, cur_imm;
    logic [31:0] base_v, index_v, eff_addr;
    logic        hit;
    logic [31:0] hit_data;
    logic [31:0] res_val, res_addr;

    function automatic logic [31:0] reg_lookup(input logic [255:0] r, input logic [2:0] sel);
        return r[{sel, 5'b0} +: 32];
    endfunction

    always_comb begin
        cur_kind      = '0;
        cur_regsel    = '0;
        cur_base_sel  = '0;
        cur_index_sel = '0;
        cur_base_en   = 1'b0;
        cur_index_en  = 1'b0;
        cur_scale     = '0;
        cur_disp      = '0;
        cur_imm       = '0;
        for (int k = 0; k < NUM_OPNDS; k++) begin
            if (cnt_q == 2'(k)) begin
                cur_kind      = kind_q[2*k +: 2];
                cur_regsel    = regsel_q[3*k +: 3];
                cur_base_sel  = base_sel_q[3*k +: 3];
                cur_index_sel = index_sel_q[3*k +: 3];
                cur_base_en   = base_en_q[k];
                cur_index_en  = index_en_q[k];
                cur_scale     = scale_q[2*k +: 2];
                cur_disp      = disp_q[32*k +: 32];
                cur_imm       = imm_q[32*k +: 32];
            end
        end

        base_v   = cur_base_en  ? reg_lookup(regs_q, cur_base_sel)  : 32'd0;
        index_v  = cur_index_en ? reg_lookup(regs_q, cur_index_sel) : 32'd0;
        eff_addr = base_v + (index_v << cur_scale) + cur_disp;

        // Descending scan so the lowest-numbered matching read hint wins
        hit      = 1'b0;
        hit_data = '0;
        for (int h = NUM_HINTS - 1; h >= 0; h--) begin
            if (hv_q[h] && !hw_q[h] && (ha_q[32*h +: 32] == eff_addr)) begin
                hit      = 1'b1;
                hit_data = hd_q[32*h +: 32];
            end
        end

        res_val  = '0;
        res_addr = '0;
        case (cur_kind)
            2'b01:   res_val = reg_lookup(regs_q, cur_regsel);
            2'b10:   res_val = cur_imm;
            2'b11: begin
                res_addr = eff_addr;
                res_val  = hit ? hit_data : 32'd0;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        val_d       = val_q;
        addr_d      = addr_q;
        kind_d      = kind_q;
        regsel_d    = regsel_q;
        base_sel_d  = base_sel_q;
        index_sel_d = index_sel_q;
        base_en_d   = base_en_q;
        index_en_d  = index_en_q;
        scale_d     = scale_q;
        disp_d      = disp_q;
        imm_d       = imm_q;
        regs_d      = regs_q;
        hv_d        = hv_q;
        hw_d        = hw_q;
        ha_d        = ha_q;
        hd_d        = hd_q;
`ifdef OPND_HINT_FAULT_EN
        fault_d     = fault_q;
        fault_idx_d = fault_idx_q;
`endif

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    kind_d      = opnd_kind;
                    regsel_d    = opnd_regsel;
                    base_sel_d  = opnd_base_sel;
                    index_sel_d = opnd_index_sel;
                    base_en_d   = opnd_base_en;
                    index_en_d  = opnd_index_en;
                    scale_d     = opnd_scale;
                    disp_d      = opnd_disp;
                    imm_d       = opnd_imm;
                    regs_d      = regs;
                    hv_d        = hint_valid;
                    hw_d        = hint_is_write;
                    ha_d        = hint_address;
                    hd_d        = hint_data;
                    cnt_d       = '0;
                    in_ready_d  = 1'b0;
                    state_d     = RESOLVE;
`ifdef OPND_HINT_FAULT_EN
                    fault_d     = 1'b0;
                    fault_idx_d = '0;
`endif
                end
            end
            RESOLVE: begin
                for (int k = 0; k < NUM_OPNDS; k++) begin
                    if (cnt_q == 2'(k)) begin
                        val_d[32*k +: 32]  = res_val;
                        addr_d[32*k +: 32] = res_addr;
                    end
                end
`ifdef OPND_HINT_FAULT_EN
                if ((cur_kind == 2'b11) && !hit && !fault_q) begin
                    fault_d     = 1'b1;
                    fault_idx_d = cnt_q;
                end
`endif
                if (cnt_q == LAST_SLOT) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            DONE: begin
                // out_valid rises one cycle after entering DONE; only a visible valid can drain
                out_valid_d = 1'b1;
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d    = IDLE;
                in_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            val_q       <= '0;
            addr_q      <= '0;
            kind_q      <= '0;
            regsel_q    <= '0;
            base_sel_q  <= '0;
            index_sel_q <= '0;
            base_en_q   <= '0;
            index_en_q  <= '0;
            scale_q     <= '0;
            disp_q      <= '0;
            imm_q       <= '0;
            regs_q      <= '0;
            hv_q        <= '0;
            hw_q        <= '0;
            ha_q        <= '0;
            hd_q        <= '0;
`ifdef OPND_HINT_FAULT_EN
            fault_q     <= 1'b0;
            fault_idx_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            val_q       <= val_d;
            addr_q      <= addr_d;
            kind_q      <= kind_d;
            regsel_q    <= regsel_d;
            base_sel_q  <= base_sel_d;
            index_sel_q <= index_sel_d;
            base_en_q   <= base_en_d;
            index_en_q  <= index_en_d;
            scale_q     <= scale_d;
            disp_q      <= disp_d;
            imm_q       <= imm_d;
            regs_q      <= regs_d;
            hv_q        <= hv_d;
            hw_q        <= hw_d;
            ha_q        <= ha_d;
            hd_q        <= hd_d;
`ifdef OPND_HINT_FAULT_EN
            fault_q     <= fault_d;
            fault_idx_q <= fault_idx_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign opnd_val  = val_q;
    assign opnd_addr = addr_q;
`ifdef OPND_HINT_FAULT_EN
    assign fault     = fault_q;
    assign fault_idx = fault_idx_q;
`else
    assign fault     = 1'b0;
    assign fault_idx = 2'b00;
`endif

endmodule
